// File: rtl/register_file_sb_if.sv
// Bus between the pipeline and register_file_sb: decode-side read, reserve
// and mode signals, the writeback port, and the scoreboard and fault status.
// The master modport is the pipeline side; the slave modport is the register file.
interface register_file_sb_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int RD_PORTS = 4
);
  logic                               kernel;
  logic                               wr_en;
  logic [ADDR_W-1:0]                  wr_addr;
  logic [DATA_W-1:0]                  wr_data;
  logic                               rsv_en;
  logic [ADDR_W-1:0]                  rsv_addr;
  logic [RD_PORTS-1:0][ADDR_W-1:0]    rd_addr;
  logic [RD_PORTS-1:0]                rd_used;
  logic [RD_PORTS-1:0][DATA_W-1:0]    rd_data;
  logic [RD_PORTS-1:0]                rd_busy;
  logic                               stall;
  logic                               privileged_read;
  logic                               priv_fault;
  logic                               fault_clr;
  logic [ADDR_W:0]                    busy_count;

  modport master (
    output kernel, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr, rd_used, fault_clr,
    input  rd_data, rd_busy, stall, privileged_read, priv_fault, busy_count
  );

  modport slave (
    input  kernel, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr, rd_used, fault_clr,
    output rd_data, rd_busy, stall, privileged_read, priv_fault, busy_count
  );
endinterface

// File: rtl/register_file_sb.sv
// register_file_sb: parametrised register file with a per-register busy
// scoreboard, mode-checked privileged writes and a sticky fault flag.
// Register 0 is hard zero and never busy.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module register_file_sb #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int RD_PORTS  = 4,
  parameter int PRIV_BASE = 12
) (
  input logic               clk,
  input logic               rst,
  register_file_sb_if.slave bus
);
  localparam int NREGS = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;
  localparam logic [CW-1:0] PRIV_BASE_W = CW'(PRIV_BASE);

  function automatic logic is_priv(input logic [ADDR_W-1:0] a);
    return {1'b0, a} >= PRIV_BASE_W;
  endfunction

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              fault_q, fault_d;

  logic wr_hit, rsv_hit, wr_priv, wr_ok, wr_fault, same_addr;
  logic set_new, clr_new;

  assign wr_hit    = bus.wr_en  && (bus.wr_addr  != '0);
  assign rsv_hit   = bus.rsv_en && (bus.rsv_addr != '0);
  assign wr_priv   = is_priv(bus.wr_addr);
  assign wr_ok     = wr_hit && (bus.kernel || !wr_priv);
  assign wr_fault  = wr_hit && !bus.kernel && wr_priv;
  assign same_addr = wr_hit && rsv_hit && (bus.wr_addr == bus.rsv_addr);

  // A blocked write still retires its destination; reserve beats retire.
  assign set_new = rsv_hit && !busy_q[bus.rsv_addr];
  assign clr_new = wr_hit && busy_q[bus.wr_addr] && !same_addr;

  // Next scoreboard state and incremental busy count
  always_comb begin
    busy_d = busy_q;
    if (wr_hit)  busy_d[bus.wr_addr]  = 1'b0;
    if (rsv_hit) busy_d[bus.rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
    cnt_d = cnt_q + CW'(set_new) - CW'(clr_new);
  end

  // Sticky fault: a new fault in the same cycle as a clear keeps the flag set
  always_comb begin
    fault_d = fault_q;
    if (bus.fault_clr) fault_d = 1'b0;
    if (wr_fault)      fault_d = 1'b1;
  end

  // Register array, scoreboard and status state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      busy_q  <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      if (wr_ok) regs_q[bus.wr_addr] <= bus.wr_data;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  logic [RD_PORTS-1:0][DATA_W-1:0] rd_data_c;
  logic [RD_PORTS-1:0]             rd_busy_c;
  logic [RD_PORTS-1:0]             rd_priv_c;

  // Combinational read ports; optional forwarding of a permitted write
  always_comb begin
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_data_c[p] = regs_q[bus.rd_addr[p]];
      rd_busy_c[p] = busy_q[bus.rd_addr[p]];
      rd_priv_c[p] = is_priv(bus.rd_addr[p]);
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (bus.rd_addr[p] == bus.wr_addr)) begin
        rd_data_c[p] = bus.wr_data;
        rd_busy_c[p] = same_addr;
      end
`endif
    end
  end

  assign bus.rd_data         = rd_data_c;
  assign bus.rd_busy         = rd_busy_c;
  assign bus.stall           = |(bus.rd_used & rd_busy_c);
  assign bus.privileged_read = |(bus.rd_used & rd_priv_c);
  assign bus.priv_fault      = fault_q;
  assign bus.busy_count      = cnt_q;
endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb with hand-computed expectations.
module tb_register_file_sb;
  localparam int DATA_W = 32, ADDR_W = 4, RD_PORTS = 4;

  logic clk = 1'b0;
  logic rst;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  register_file_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_PORTS(RD_PORTS)) bus ();

  register_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_PORTS(RD_PORTS), .PRIV_BASE(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past a rising edge and let outputs settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = 1'b0; bus.rsv_en = 1'b0; bus.fault_clr = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
  endtask

  task automatic rsv(input logic [3:0] a);
    bus.rsv_en = 1'b1; bus.rsv_addr = a;
  endtask

  logic [31:0] exp_byp;
  logic        exp_bbusy;

  initial begin
    rst = 1'b1;
    bus.kernel = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0; bus.rd_addr = '0; bus.rd_used = '0;
    bus.fault_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    bus.rd_addr[0] = 4'd3;
    #1;
    chk("rst_data",  64'(bus.rd_data[0]), 64'h0);
    chk("rst_count", 64'(bus.busy_count), 64'h0);
    chk("rst_fault", 64'(bus.priv_fault), 64'h0);
    chk("rst_stall", 64'(bus.stall),      64'h0);

    // User write to a non-privileged register
    wr(4'd3, 32'hDEADBEEF); tick(); idle();
    chk("r3_data", 64'(bus.rd_data[0]), 64'hDEADBEEF);

    // Register 0 ignores writes and reserves
    wr(4'd0, 32'h1234); rsv(4'd0); tick(); idle();
    bus.rd_addr[1] = 4'd0; #1;
    chk("r0_data",  64'(bus.rd_data[1]), 64'h0);
    chk("r0_busy",  64'(bus.rd_busy[1]), 64'h0);
    chk("r0_count", 64'(bus.busy_count), 64'h0);

    // Reserve r5, stall only when the operand is used
    rsv(4'd5); tick(); idle();
    bus.rd_addr[1] = 4'd5; bus.rd_used = 4'b0010; #1;
    chk("r5_busy",   64'(bus.rd_busy[1]), 64'h1);
    chk("r5_count",  64'(bus.busy_count), 64'h1);
    chk("r5_stall",  64'(bus.stall),      64'h1);
    bus.rd_used = 4'b1101; #1;
    chk("r5_nostall", 64'(bus.stall),     64'h0);
    bus.rd_used = 4'b0010;

    // Writeback retires r5
    wr(4'd5, 32'd7); tick(); idle();
    chk("r5_wb_busy",  64'(bus.rd_busy[1]), 64'h0);
    chk("r5_wb_count", 64'(bus.busy_count), 64'h0);
    chk("r5_wb_data",  64'(bus.rd_data[1]), 64'h7);
    chk("r5_wb_stall", 64'(bus.stall),      64'h0);

    // Writeback to a non-busy register leaves the count alone
    wr(4'd3, 32'h11); tick(); idle();
    chk("nb_count", 64'(bus.busy_count), 64'h0);

    // User write to privileged r13 is dropped and faults
    bus.kernel = 1'b0;
    wr(4'd13, 32'h55); tick(); idle();
    bus.rd_addr[2] = 4'd13; bus.rd_used = 4'b0000; #1;
    chk("r13_user_data", 64'(bus.rd_data[2]), 64'h0);
    chk("r13_fault",     64'(bus.priv_fault), 64'h1);
    chk("priv_rd_unused", 64'(bus.privileged_read), 64'h0);
    bus.rd_used = 4'b0100; #1;
    chk("priv_rd_used",  64'(bus.privileged_read), 64'h1);
    bus.rd_used = 4'b0000;
    tick();
    chk("fault_held", 64'(bus.priv_fault), 64'h1);
    bus.fault_clr = 1'b1; tick(); idle();
    chk("fault_clr", 64'(bus.priv_fault), 64'h0);

    // Kernel write to r13 succeeds
    bus.kernel = 1'b1;
    wr(4'd13, 32'h55); tick(); idle();
    chk("r13_kern_data",  64'(bus.rd_data[2]), 64'h55);
    chk("r13_kern_fault", 64'(bus.priv_fault), 64'h0);
    bus.kernel = 1'b0;

    // Fault set and clear in the same cycle: set wins
    wr(4'd14, 32'h99); bus.fault_clr = 1'b1; tick(); idle();
    chk("fault_set_wins", 64'(bus.priv_fault), 64'h1);
    bus.fault_clr = 1'b1; tick(); idle();
    chk("fault_clr2", 64'(bus.priv_fault), 64'h0);

    // Write and reserve r4 in the same cycle: data lands, reserve wins
    wr(4'd4, 32'd9); rsv(4'd4); tick(); idle();
    bus.rd_addr[3] = 4'd4; #1;
    chk("r4_data",  64'(bus.rd_data[3]), 64'h9);
    chk("r4_busy",  64'(bus.rd_busy[3]), 64'h1);
    chk("r4_count", 64'(bus.busy_count), 64'h1);

    // Double reserve of r2 counts once
    rsv(4'd2); tick(); idle();
    chk("r2_count1", 64'(bus.busy_count), 64'h2);
    rsv(4'd2); tick(); idle();
    chk("r2_count2", 64'(bus.busy_count), 64'h2);

    // Same-cycle read of a register being written (r6 holds 0)
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'hA5;
`else
    exp_byp = 32'h0;
`endif
    bus.rd_addr[2] = 4'd6;
    wr(4'd6, 32'hA5); #1;
    chk("byp_data", 64'(bus.rd_data[2]), 64'(exp_byp));
    chk("byp_busy", 64'(bus.rd_busy[2]), 64'h0);
    tick(); idle();
    chk("r6_data", 64'(bus.rd_data[2]), 64'hA5);

    // Same-cycle write+reserve on a read address (r7 holds 0, not busy)
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'h77; exp_bbusy = 1'b1;
`else
    exp_byp = 32'h0;  exp_bbusy = 1'b0;
`endif
    bus.rd_addr[2] = 4'd7;
    wr(4'd7, 32'h77); rsv(4'd7); #1;
    chk("byp_rsv_data", 64'(bus.rd_data[2]), 64'(exp_byp));
    chk("byp_rsv_busy", 64'(bus.rd_busy[2]), 64'(exp_bbusy));
    tick(); idle();
    chk("r7_count", 64'(bus.busy_count), 64'h3);

    // Dropped privileged write is never forwarded
    bus.rd_addr[3] = 4'd15;
    wr(4'd15, 32'hCAFE); #1;
    chk("nobyp_priv", 64'(bus.rd_data[3]), 64'h0);
    tick(); idle();
    chk("r15_fault", 64'(bus.priv_fault), 64'h1);

    // Mid-run reset with r2, r4, r7 busy and a pending fault
    bus.rd_addr[0] = 4'd3; bus.rd_addr[1] = 4'd4; bus.rd_addr[2] = 4'd13;
    rst = 1'b1; wr(4'd3, 32'hFFFF); rsv(4'd9); tick(); idle();
    rst = 1'b0; #1;
    chk("mrst_r3",    64'(bus.rd_data[0]), 64'h0);
    chk("mrst_r4",    64'(bus.rd_data[1]), 64'h0);
    chk("mrst_r13",   64'(bus.rd_data[2]), 64'h0);
    chk("mrst_busy",  64'(bus.rd_busy[1]), 64'h0);
    chk("mrst_count", 64'(bus.busy_count), 64'h0);
    chk("mrst_fault", 64'(bus.priv_fault), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the fixed 16x32, four-read-port SKIP register file.
- Configurable data width, register count and read-port count.
- Adds a per-register busy scoreboard (reserve on issue, retire on writeback), mode-checked privileged writes with a sticky fault flag, and a registered busy-count for stall logic.
- Sits between decode (reserve, read) and writeback (write) in the SKIP pipeline.

Parameters:
- DATA_W, 32: register data width in bits.
- ADDR_W, 4: register address width; the file holds NREGS = 2**ADDR_W registers.
- RD_PORTS, 4: number of combinational read ports.
- PRIV_BASE, 12: registers with index >= PRIV_BASE need kernel mode.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- kernel  in  1  current mode; 1 = kernel.
- wr_en  in  1  writeback valid.
- wr_addr  in  ADDR_W  writeback register.
- wr_data  in  DATA_W  writeback value.
- rsv_en  in  1  reserve request from issue.
- rsv_addr  in  ADDR_W  destination register to mark busy.
- rd_addr  in  RD_PORTS*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W].
- rd_used  in  RD_PORTS  per-port "operand actually used" mask.
- rd_data  out  RD_PORTS*DATA_W  read data, packed like rd_addr.
- rd_busy  out  RD_PORTS  per-port: addressed register is busy.
- stall  out  1  OR over i of (rd_used[i] & rd_busy[i]).
- privileged_read  out  1  OR over i of (rd_used[i] & rd_addr[i] >= PRIV_BASE).
- priv_fault  out  1  sticky: a user-mode write targeted a privileged register.
- fault_clr  in  1  clears priv_fault.
- busy_count  out  ADDR_W+1  number of busy registers (registered).

Behaviour:
- Reset (rst=1 at an edge):
  - All registers become 0; all busy bits 0; priv_fault 0; busy_count 0.
  - rst overrides every other input in that cycle.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and reserves to it are ignored; it does not count toward busy_count.
- Reads:
  - Combinational: rd_data[i] = reg[rd_addr[i]] and rd_busy[i] = busy[rd_addr[i]], both as of the current cycle.
  - Zero latency, no bypass (see the optional feature).
- Write, when wr_en=1 and wr_addr!=0:
  - If kernel=1 or wr_addr < PRIV_BASE: reg updates to wr_data at the edge.
  - Otherwise: the data is dropped and priv_fault is set to 1 at the edge.
  - In both cases busy[wr_addr] clears (the retire still occurs).
- Reserve, when rsv_en=1 and rsv_addr!=0: busy[rsv_addr] sets at the edge. No mode check on reserve.
- Simultaneous write and reserve to the same address: data is written and busy ends at 1 (reserve wins).
- Reserve of an already-busy register: busy stays 1 and busy_count is unchanged.
- Write to a non-busy register: busy stays 0 and busy_count is unchanged.
- busy_count next value = current + (busy bit newly set) - (busy bit newly cleared). It always equals the popcount of busy[NREGS-1:1] and never wraps.
- Simultaneous priv_fault set and fault_clr: set wins.
- privileged_read is independent of kernel; the trap decision belongs to decode.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined, for each port with wr_en=1 and rd_addr[i]==wr_addr!=0 and the write permitted:
  - rd_data[i] = wr_data.
  - rd_busy[i] = 0, unless rsv_en=1 and rsv_addr==wr_addr in the same cycle; in that case the forwarded data is still shown but rd_busy[i]=1.
- A dropped privileged write is never forwarded.
- When not defined, reads return pre-edge register contents and busy state, with no forwarding.

Test Plan:
- Reset, then kernel=0; write r3=0xDEADBEEF → next cycle rd_addr[0]=3 gives 0xDEADBEEF. Write r0=0x1234 → reads 0, busy_count 0.
- Reserve r5 → next cycle rd_busy=1, busy_count=1. rd_used[1]=1 on r5 → stall=1. Write r5=7 → busy clears, busy_count=0, reads 7.
- kernel=0, write r13=0x55 → r13 unchanged, priv_fault=1 and held. fault_clr=1 → 0. Repeat with kernel=1 → r13=0x55, no fault.
- Same cycle: reserve and write r4=9 → r4=9, busy[4]=1, busy_count +1. Reserve r2 twice → busy_count increments once.
- With REGFILE_BYPASS_EN: write r6=0xA5 with rd_addr[2]=6 in the same cycle → rd_data=0xA5, rd_busy=0. Without the macro → old value returned.
- Assert rst mid-run with 3 registers busy and priv_fault=1 → next cycle all reads 0, busy_count 0, priv_fault 0.
